// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x6 switch-matrix keypad model with bounce, hold and release timing
// Drives active-low kpcol from the scanner's active-low kprow for one latched key at a time.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 50000,
  parameter int BOUNCE_PULSES = 3,
  parameter int BOUNCE_PERIOD = 500,
  parameter int GAP_CYCLES    = 50000
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [3:0] kprow,
  output logic [5:0] kpcol,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_key,
  output logic       busy,
  output logic       key_down,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_ON,
    HOLD,
    BOUNCE_OFF,
    GAP
  } state_e;

  localparam int BOUNCE_LEN = 2 * BOUNCE_PULSES * BOUNCE_PERIOD;
  localparam int MAX_HG     = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_LEN    = (MAX_HG > BOUNCE_LEN) ? MAX_HG : BOUNCE_LEN;
  localparam int CW         = $clog2(MAX_LEN + 1);
  localparam int PW         = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] BOUNCE_LAST = CW'((BOUNCE_LEN > 0) ? BOUNCE_LEN - 1 : 0);
  localparam logic [PW-1:0] HALF_LAST   = PW'(BOUNCE_PERIOD - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   half_q, half_d;
  logic            key_down_q, key_down_d;
  logic [1:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [1:0]      key_row;
  logic [2:0]      key_col;
  logic            key_legal;

  // Keycode split into row = key/6, col = key%6 without a divider.
  always_comb begin
    key_row   = 2'd0;
    key_col   = 3'd0;
    key_legal = (cmd_key <= 5'd23);
    if (cmd_key < 5'd6) begin
      key_row = 2'd0;
      key_col = cmd_key[2:0];
    end else if (cmd_key < 5'd12) begin
      key_row = 2'd1;
      key_col = 3'(cmd_key - 5'd6);
    end else if (cmd_key < 5'd18) begin
      key_row = 2'd2;
      key_col = 3'(cmd_key - 5'd12);
    end else if (cmd_key < 5'd24) begin
      key_row = 2'd3;
      key_col = 3'(cmd_key - 5'd18);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    half_d     = half_q;
    key_down_d = key_down_q;
    row_d      = row_q;
    col_d      = col_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        key_down_d = 1'b0;
        cnt_d      = '0;
        half_d     = '0;
        if (cmd_valid) begin
          if (key_legal) begin
            row_d      = key_row;
            col_d      = key_col;
            key_down_d = 1'b1;
            state_d    = (BOUNCE_PULSES == 0) ? HOLD : BOUNCE_ON;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      BOUNCE_ON, BOUNCE_OFF: begin
        if (cnt_q == BOUNCE_LAST) begin
          cnt_d  = '0;
          half_d = '0;
          if (state_q == BOUNCE_ON) begin
            state_d    = HOLD;
            key_down_d = 1'b1;
          end else begin
            state_d    = GAP;
            key_down_d = 1'b0;
          end
        end else if (half_q == HALF_LAST) begin
          half_d     = '0;
          key_down_d = !key_down_q;
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      HOLD: begin
        key_down_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d      = '0;
          half_d     = '0;
          key_down_d = 1'b0;
          state_d    = (BOUNCE_PULSES == 0) ? GAP : BOUNCE_OFF;
        end
      end

      GAP: begin
        key_down_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        key_down_d = 1'b0;
        cnt_d      = '0;
        half_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      key_down_q <= 1'b0;
      row_q      <= 2'd0;
      col_q      <= 3'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      key_down_q <= key_down_d;
      row_q      <= row_d;
      col_q      <= col_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Physical switch: zero-cycle path from the latched row line to the latched column.
  always_comb begin
    kpcol = 6'h3F;
    if (key_down_q && !kprow[row_q]) begin
      kpcol[col_q] = 1'b0;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = !cmd_ready;
  assign key_down  = key_down_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - directed self-checking bench for keypad_emulator
module tb_keypad_emulator;

  logic       clk5 = 1'b0;
  logic       reset;
  logic [3:0] kprow;
  logic [5:0] kpcol;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_key;
  logic       busy;
  logic       key_down;
  logic       done;
  logic       err;

  logic       nb_cmd_valid;
  logic [4:0] nb_cmd_key;
  logic [5:0] nb_kpcol;
  logic       nb_cmd_ready;
  logic       nb_busy;
  logic       nb_key_down;
  logic       nb_done;
  logic       nb_err;

  int n_total = 0;
  int n_pass  = 0;

  always #100 clk5 = ~clk5;

  keypad_emulator #(
    .HOLD_CYCLES(20), .BOUNCE_PULSES(2), .BOUNCE_PERIOD(3), .GAP_CYCLES(10)
  ) u_dut (
    .clk5(clk5), .reset(reset), .kprow(kprow), .kpcol(kpcol),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .busy(busy), .key_down(key_down), .done(done), .err(err)
  );

  keypad_emulator #(
    .HOLD_CYCLES(20), .BOUNCE_PULSES(0), .BOUNCE_PERIOD(3), .GAP_CYCLES(10)
  ) u_dut_nb (
    .clk5(clk5), .reset(reset), .kprow(kprow), .kpcol(nb_kpcol),
    .cmd_valid(nb_cmd_valid), .cmd_ready(nb_cmd_ready), .cmd_key(nb_cmd_key),
    .busy(nb_busy), .key_down(nb_key_down), .done(nb_done), .err(nb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk5);
    #1;
  endtask

  // Hand-derived contact timeline for key 14, accept edge = cycle 0.
  function automatic logic exp_kd(input int c);
    return (c >= 1 && c <= 3) || (c >= 7 && c <= 9) || (c >= 13 && c <= 32) ||
           (c >= 36 && c <= 38) || (c >= 42 && c <= 44);
  endfunction

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    logic done_seen;
    reset        = 1'b1;
    kprow        = 4'h0;
    cmd_valid    = 1'b0;
    cmd_key      = 5'd0;
    nb_cmd_valid = 1'b0;
    nb_cmd_key   = 5'd0;

    tick();
    tick();
    chk("rst_kpcol", kpcol, 6'h3F);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key_down", key_down, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    tick();

    // Full timing of key 14 (row 2, col 2)
    kprow     = 4'b1011;
    cmd_key   = 5'd14;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      chk($sformatf("kd_c%0d", c), key_down, exp_kd(c));
      chk($sformatf("busy_c%0d", c), busy, (c >= 1 && c <= 54));
      chk($sformatf("done_c%0d", c), done, (c == 55));
      chk($sformatf("kpcol_c%0d", c), kpcol, exp_kd(c) ? 6'h3B : 6'h3F);
      tick();
    end
    chk("post_done", done, 1'b0);

    // Row gating during HOLD
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (14) tick();
    chk("gate_kd", key_down, 1'b1);
    kprow = 4'b1110; #1 chk("gate_r0", kpcol, 6'h3F);
    kprow = 4'b1101; #1 chk("gate_r1", kpcol, 6'h3F);
    kprow = 4'b1011; #1 chk("gate_r2", kpcol, 6'h3B);
    kprow = 4'b0111; #1 chk("gate_r3", kpcol, 6'h3F);
    kprow = 4'b0000; #1 chk("gate_all", kpcol, 6'h3B);
    wait_done("gate_done");
    tick();

    // Illegal keycode
    kprow     = 4'h0;
    cmd_key   = 5'd24;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("ill_err", err, 1'b1);
    chk("ill_ready", cmd_ready, 1'b1);
    chk("ill_busy", busy, 1'b0);
    chk("ill_kpcol", kpcol, 6'h3F);
    tick();
    chk("ill_err_clr", err, 1'b0);
    chk("ill_idle", cmd_ready, 1'b1);

    // Back-to-back: key 0, then key 23 held on cmd_key while busy and on done cycle
    kprow     = 4'b0111;
    cmd_key   = 5'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_key = 5'd23;
    chk("b2b_busy", busy, 1'b1);
    repeat (19) tick();
    chk("b2b_k0_r3", kpcol, 6'h3F);
    kprow = 4'b1110; #1 chk("b2b_k0_r0", kpcol, 6'h3E);
    wait_done("b2b_done");
    chk("b2b_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_accept", busy, 1'b1);
    repeat (15) tick();
    kprow = 4'b0111; #1 chk("b2b_k23", kpcol, 6'h1F);
    kprow = 4'b1110; #1 chk("b2b_k23_r0", kpcol, 6'h3F);
    kprow = 4'b0111;

    // Reset mid-HOLD (cycle 20 of key 23)
    repeat (4) tick();
    chk("mid_kd", key_down, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_kd_rst", key_down, 1'b0);
    chk("mid_kpcol", kpcol, 6'h3F);
    chk("mid_ready", cmd_ready, 1'b1);
    done_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) done_seen = 1'b1;
      tick();
    end
    chk("mid_no_done", done_seen, 1'b0);

    // Bounce-free build: key 5 (row 0, col 5)
    kprow        = 4'b1110;
    nb_cmd_key   = 5'd5;
    nb_cmd_valid = 1'b1;
    tick();
    nb_cmd_valid = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      chk($sformatf("nb_kd_c%0d", c), nb_key_down, (c >= 1 && c <= 20));
      chk($sformatf("nb_kpcol_c%0d", c), nb_kpcol, (c >= 1 && c <= 20) ? 6'h1F : 6'h3F);
      chk($sformatf("nb_done_c%0d", c), nb_done, (c == 31));
      tick();
    end
    chk("nb_err", nb_err, 1'b0);
    chk("nb_ready", nb_cmd_ready, 1'b1);
    chk("nb_busy", nb_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
